// File: rtl/debounce_bank.sv
// debounce_bank: multi-channel pushbutton/switch debouncer with edge pulses.
// Every channel has a 2-FF synchroniser, its own stability counter and a
// small FSM that drives a registered filtered level plus rise/fall pulses.
// MODE 0 (delayed) waits for a full stable window before changing the output.
// MODE 1 (early) follows the first edge at once, then ignores the input
// for the window.

module debounce_bank #(
   parameter int   CHANNELS      = 4,
   parameter int   STABLE_CYCLES = 2_000_000,
   parameter int   MODE          = 0,
   parameter logic INIT_LEVEL    = 1'b0
) (
   input  logic                clk,
   input  logic                reset,
   input  logic                enable,
   input  logic [CHANNELS-1:0] noisy,
   output logic [CHANNELS-1:0] debounced,
   output logic [CHANNELS-1:0] rise,
   output logic [CHANNELS-1:0] fall,
   output logic                changed
);

   // Sized so the counter can hold STABLE_CYCLES itself and never wraps.
   localparam int CNT_W = $clog2(STABLE_CYCLES + 1);
   localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(STABLE_CYCLES);
   localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
   localparam bit               EARLY    = (MODE != 0);

   // COUNT is only reached in delayed mode, LOCK only in early mode.
   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      COUNT = 2'd1,
      LOCK  = 2'd2
   } state_t;

   genvar gi;
   generate
      for (gi = 0; gi < CHANNELS; gi++) begin : g_ch
         logic             s1_reg;
         logic             s2_reg;
         state_t           state_reg;
         logic [CNT_W-1:0] cnt_reg;
         logic             db_reg;
         logic             rise_reg;
         logic             fall_reg;

         // Two-stage synchroniser; keeps sampling even while disabled.
         always_ff @(posedge clk or posedge reset) begin
            if (reset) begin
               s1_reg <= INIT_LEVEL;
               s2_reg <= INIT_LEVEL;
            end else begin
               s1_reg <= noisy[gi];
               s2_reg <= s1_reg;
            end
         end

         // Channel FSM: stability/lockout counter, filtered level and pulses.
         always_ff @(posedge clk or posedge reset) begin
            if (reset) begin
               state_reg <= IDLE;
               cnt_reg   <= '0;
               db_reg    <= INIT_LEVEL;
               rise_reg  <= 1'b0;
               fall_reg  <= 1'b0;
            end else if (!enable) begin
               // Frozen: state, counter and level hold; pulses drop.
               rise_reg <= 1'b0;
               fall_reg <= 1'b0;
            end else begin
               rise_reg <= 1'b0;
               fall_reg <= 1'b0;
               case (state_reg)
                  IDLE: begin
                     if (s2_reg != db_reg) begin
                        cnt_reg <= CNT_ONE;
                        if (EARLY) begin
                           // Follow the edge now, then lock out bounces.
                           db_reg    <= s2_reg;
                           rise_reg  <= s2_reg;
                           fall_reg  <= ~s2_reg;
                           state_reg <= LOCK;
                        end else begin
                           state_reg <= COUNT;
                        end
                     end else begin
                        cnt_reg <= '0;
                     end
                  end
                  COUNT: begin
                     if (s2_reg == db_reg) begin
                        // Input bounced back: abandon this attempt silently.
                        state_reg <= IDLE;
                        cnt_reg   <= '0;
                     end else if (cnt_reg == CNT_MAX) begin
                        db_reg    <= s2_reg;
                        rise_reg  <= s2_reg;
                        fall_reg  <= ~s2_reg;
                        state_reg <= IDLE;
                        cnt_reg   <= '0;
                     end else begin
                        cnt_reg <= cnt_reg + CNT_ONE;
                     end
                  end
                  LOCK: begin
                     // Input is ignored until the window has elapsed.
                     if (cnt_reg == CNT_MAX) begin
                        state_reg <= IDLE;
                        cnt_reg   <= '0;
                     end else begin
                        cnt_reg <= cnt_reg + CNT_ONE;
                     end
                  end
                  default: begin
                     state_reg <= IDLE;
                     cnt_reg   <= '0;
                  end
               endcase
            end
         end

         assign debounced[gi] = db_reg;
         assign rise[gi]      = rise_reg;
         assign fall[gi]      = fall_reg;
      end
   endgenerate

   // Summary flag straight from the registered pulses.
   assign changed = |(rise | fall);

endmodule

// File: tb/tb_debounce_bank.sv
// Bench for debounce_bank: one delayed-mode and one early-mode instance share
// clock, reset and enable. Expected output events are queued as stimulus is
// applied and matched cycle by cycle against both instances.

module tb_debounce_bank;

   localparam int CH = 4;
   localparam int SC = 8;

   logic          clk = 1'b0;
   logic          reset;
   logic          enable;
   logic [CH-1:0] noisy0, noisy1;
   logic [CH-1:0] db0, rise0, fall0;
   logic [CH-1:0] db1, rise1, fall1;
   logic          changed0, changed1;

   always #5 clk = ~clk;

   debounce_bank #(.CHANNELS(CH), .STABLE_CYCLES(SC), .MODE(0), .INIT_LEVEL(1'b0)) dut0 (
      .clk(clk), .reset(reset), .enable(enable), .noisy(noisy0),
      .debounced(db0), .rise(rise0), .fall(fall0), .changed(changed0)
   );

   debounce_bank #(.CHANNELS(CH), .STABLE_CYCLES(SC), .MODE(1), .INIT_LEVEL(1'b0)) dut1 (
      .clk(clk), .reset(reset), .enable(enable), .noisy(noisy1),
      .debounced(db1), .rise(rise1), .fall(fall1), .changed(changed1)
   );

   typedef struct {
      int            cyc;
      logic [CH-1:0] rise;
      logic [CH-1:0] fall;
      logic [CH-1:0] db;
   } ev_t;

   ev_t           q0[$];
   ev_t           q1[$];
   int            cyc      = 0;
   int            n_checks = 0;
   int            n_pass   = 0;
   bit            mon_en   = 1'b0;
   logic [CH-1:0] lvl0_q, lvl1_q;
   logic [CH-1:0] exp_db0, exp_db1;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic check_eq(input string tag, input int got, input int want);
      n_checks++;
      if (got == want) n_pass++;
      else $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, want, cyc);
   endtask

   task automatic tick(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic push0(input int at, input logic [CH-1:0] r, input logic [CH-1:0] f);
      ev_t e;
      lvl0_q = (lvl0_q | r) & ~f;
      e.cyc = at; e.rise = r; e.fall = f; e.db = lvl0_q;
      q0.push_back(e);
   endtask

   task automatic push1(input int at, input logic [CH-1:0] r, input logic [CH-1:0] f);
      ev_t e;
      lvl1_q = (lvl1_q | r) & ~f;
      e.cyc = at; e.rise = r; e.fall = f; e.db = lvl1_q;
      q1.push_back(e);
   endtask

   // Monitor: every cycle compare both instances against the scoreboard.
   always @(negedge clk) begin
      ev_t           e;
      logic [CH-1:0] er0, ef0, er1, ef1;
      if (!mon_en) begin
         exp_db0 = '0;
         exp_db1 = '0;
      end else begin
         er0 = '0; ef0 = '0; er1 = '0; ef1 = '0;
         if (q0.size() > 0 && q0[0].cyc == cyc) begin
            e = q0.pop_front();
            er0 = e.rise; ef0 = e.fall; exp_db0 = e.db;
            $display("cycle %0d dut0: rise=%b fall=%b db=%b (want rise=%b fall=%b db=%b)",
                     cyc, rise0, fall0, db0, er0, ef0, exp_db0);
         end
         if (q1.size() > 0 && q1[0].cyc == cyc) begin
            e = q1.pop_front();
            er1 = e.rise; ef1 = e.fall; exp_db1 = e.db;
            $display("cycle %0d dut1: rise=%b fall=%b db=%b (want rise=%b fall=%b db=%b)",
                     cyc, rise1, fall1, db1, er1, ef1, exp_db1);
         end
         check_eq("d0_db",   int'(db0),      int'(exp_db0));
         check_eq("d0_rise", int'(rise0),    int'(er0));
         check_eq("d0_fall", int'(fall0),    int'(ef0));
         check_eq("d0_chg",  int'(changed0), int'(|(er0 | ef0)));
         check_eq("d1_db",   int'(db1),      int'(exp_db1));
         check_eq("d1_rise", int'(rise1),    int'(er1));
         check_eq("d1_fall", int'(fall1),    int'(ef1));
         check_eq("d1_chg",  int'(changed1), int'(|(er1 | ef1)));
         if (q0.size() > 0 && q0[0].cyc < cyc) begin
            e = q0.pop_front();
            check_eq("d0_missed_event_cycle", cyc, e.cyc);
         end
         if (q1.size() > 0 && q1[0].cyc < cyc) begin
            e = q1.pop_front();
            check_eq("d1_missed_event_cycle", cyc, e.cyc);
         end
      end
   end

   initial begin
      int c0;
      reset  = 1'b1;
      enable = 1'b1;
      noisy0 = '0;
      noisy1 = '0;
      lvl0_q = '0;
      lvl1_q = '0;
      tick(3);

      // Reset state
      check_eq("rst_db0",   int'(db0),      0);
      check_eq("rst_rise0", int'(rise0),    0);
      check_eq("rst_fall0", int'(fall0),    0);
      check_eq("rst_chg0",  int'(changed0), 0);
      check_eq("rst_db1",   int'(db1),      0);
      check_eq("rst_rise1", int'(rise1),    0);
      check_eq("rst_fall1", int'(fall1),    0);
      check_eq("rst_chg1",  int'(changed1), 0);
      reset  = 1'b0;
      mon_en = 1'b1;
      tick(2);

      // Early mode: ch2 steps high then bounces, ends low during lockout
      c0 = cyc;
      noisy1[2] = 1'b1;
      push1(c0 + 3,  4'b0100, 4'b0000);
      push1(c0 + 12, 4'b0000, 4'b0100);
      tick(1); noisy1[2] = 1'b0;
      tick(1); noisy1[2] = 1'b1;
      tick(1); noisy1[2] = 1'b0;
      tick(1); noisy1[2] = 1'b1;
      tick(1); noisy1[2] = 1'b0;
      tick(22);

      // Delayed mode: clean step on ch0 and back
      c0 = cyc; noisy0[0] = 1'b1; push0(c0 + 11, 4'b0001, 4'b0000); tick(13);
      c0 = cyc; noisy0[0] = 1'b0; push0(c0 + 11, 4'b0000, 4'b0001); tick(13);

      // Delayed mode: ch1 bursts, then holds high
      noisy0[1] = 1'b1; tick(3);
      noisy0[1] = 1'b0; tick(3);
      noisy0[1] = 1'b1; tick(3);
      noisy0[1] = 1'b0; tick(3);
      c0 = cyc; noisy0[1] = 1'b1; push0(c0 + 11, 4'b0010, 4'b0000); tick(13);
      c0 = cyc; noisy0[1] = 1'b0; push0(c0 + 11, 4'b0000, 4'b0010); tick(13);

      // All channels at once
      c0 = cyc; noisy0 = 4'b1111; push0(c0 + 11, 4'b1111, 4'b0000); tick(13);
      c0 = cyc; noisy0 = 4'b0000; push0(c0 + 11, 4'b0000, 4'b1111); tick(13);

      // Enable low for 5 cycles mid-count delays the change by 5
      c0 = cyc; noisy0[0] = 1'b1; push0(c0 + 16, 4'b0001, 4'b0000);
      tick(5); enable = 1'b0;
      tick(5); enable = 1'b1;
      tick(8);
      c0 = cyc; noisy0[0] = 1'b0; push0(c0 + 11, 4'b0000, 4'b0001); tick(13);

      // Reset mid-count with ch3 already high
      c0 = cyc; noisy0[3] = 1'b1; push0(c0 + 11, 4'b1000, 4'b0000); tick(13);
      noisy0[2] = 1'b1;
      tick(8);
      reset  = 1'b1;
      mon_en = 1'b0;
      #1;
      check_eq("async_rst_db0",   int'(db0),      0);
      check_eq("async_rst_rise0", int'(rise0),    0);
      check_eq("async_rst_chg0",  int'(changed0), 0);
      check_eq("async_rst_db1",   int'(db1),      0);
      q0.delete();
      q1.delete();
      lvl0_q = '0;
      lvl1_q = '0;
      tick(1);
      check_eq("held_rst_db0", int'(db0), 0);
      reset  = 1'b0;
      mon_en = 1'b1;
      c0 = cyc; push0(c0 + 11, 4'b1100, 4'b0000); tick(13);
      c0 = cyc; noisy0 = 4'b0000; push0(c0 + 11, 4'b0000, 4'b1100); tick(13);

      check_eq("q0_drained", q0.size(), 0);
      check_eq("q1_drained", q1.size(), 0);
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
